// File: rtl/reg_file.sv
// reg_file: architectural register file with rename tags for an out-of-order core.
// Holds 32 x 32-bit values, a busy bit per register and the RoB tag that will
// produce each busy register. Operand queries are purely combinational and
// always see the state from before the current clock edge.
//
// Optional feature: define REG_COMMIT_BYPASS_EN to forward a same-cycle commit
// straight to a waiting operand. Without it the operand resolves only from
// the stored state and the RoB readiness lookup.
//
// ROB_SIZE_WIDTH normally comes from the shared core configuration include; a
// default is provided here so the block also builds standalone.

`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module reg_file (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic [`ROB_SIZE_WIDTH-1:0]   issue_rob_id,
  input  logic [4:0]                   issue_rd,
  input  logic [`ROB_SIZE_WIDTH-1:0]   commit_rob_id,
  input  logic [4:0]                   commit_rd,
  input  logic [31:0]                  commit_value,
  input  logic                         clear,
  input  logic [4:0]                   rs1,
  input  logic [4:0]                   rs2,
  output logic [31:0]                  val1,
  output logic [31:0]                  val2,
  output logic [`ROB_SIZE_WIDTH-1:0]   dep1,
  output logic [`ROB_SIZE_WIDTH-1:0]   dep2,
  output logic                         has_dep1,
  output logic                         has_dep2,
  output logic [`ROB_SIZE_WIDTH-1:0]   get_rob_id1,
  output logic [`ROB_SIZE_WIDTH-1:0]   get_rob_id2,
  input  logic                         get_ready1,
  input  logic                         get_ready2,
  input  logic [31:0]                  get_value1,
  input  logic [31:0]                  get_value2
);

  localparam int RW = `ROB_SIZE_WIDTH;
  localparam int RES_W = 32 + 1 + RW;

  // Architectural state.
  logic [31:0]   r_values [32];
  logic [31:0]   r_busy;
  logic [RW-1:0] r_tags   [32];

  // Decoded update controls for the current edge.
  logic w_commit_en;
  logic w_commit_tag_hit;
  logic w_issue_en;
  logic w_clear_en;

  // Per-operand lookup of the stored state.
  logic [31:0]   w_sval1;
  logic [31:0]   w_sval2;
  logic          w_sbusy1;
  logic          w_sbusy2;
  logic [RW-1:0] w_stag1;
  logic [RW-1:0] w_stag2;

  // Commit-forwarding hits (always 0 when the bypass is compiled out).
  logic w_byp1;
  logic w_byp2;

  // Packed resolution results {value, has_dep, dep}.
  logic [RES_W-1:0] w_res1;
  logic [RES_W-1:0] w_res2;

  // Resolve one operand. Priority: idle register, then commit forwarding,
  // then the RoB lookup, otherwise the operand waits on its tag. x0 is
  // forced to a ready zero regardless of anything else.
  function automatic logic [RES_W-1:0] resolve_operand(
    input logic [4:0]    rs,
    input logic          busy,
    input logic [RW-1:0] tag,
    input logic [31:0]   value,
    input logic          byp_hit,
    input logic [31:0]   byp_value,
    input logic          rob_ready,
    input logic [31:0]   rob_value
  );
    logic [RES_W-1:0] res;
    res = {RES_W{1'b0}};
    if (rs == 5'd0) begin
      res = {32'd0, 1'b0, {RW{1'b0}}};
    end else if (!busy) begin
      res = {value, 1'b0, {RW{1'b0}}};
    end else if (byp_hit) begin
      res = {byp_value, 1'b0, {RW{1'b0}}};
    end else if (rob_ready) begin
      res = {rob_value, 1'b0, {RW{1'b0}}};
    end else begin
      res = {32'd0, 1'b1, tag};
    end
    return res;
  endfunction

  // Decode which updates apply on the coming edge; clear overrides issue and
  // busy release, but never the value write of a commit.
  always_comb begin
    w_commit_en      = 1'b0;
    w_commit_tag_hit = 1'b0;
    w_issue_en       = 1'b0;
    w_clear_en       = 1'b0;
    if (rdy) begin
      w_commit_en      = (commit_rd != 5'd0);
      w_commit_tag_hit = (commit_rd != 5'd0) && (r_tags[commit_rd] == commit_rob_id);
      w_clear_en       = clear;
      w_issue_en       = (issue_rd != 5'd0) && !clear;
    end else begin
      w_commit_en      = 1'b0;
      w_commit_tag_hit = 1'b0;
      w_issue_en       = 1'b0;
      w_clear_en       = 1'b0;
    end
  end

  // Value array: written by every enabled commit, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_values[i] <= 32'd0;
      end
    end else if (w_commit_en) begin
      r_values[commit_rd] <= commit_value;
    end
  end

  // Busy bits: clear wipes all; otherwise a matching commit releases and an
  // issue sets, with the issue applied last so it wins on a shared rd.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 32'd0;
    end else if (w_clear_en) begin
      r_busy <= 32'd0;
    end else begin
      if (w_commit_tag_hit) begin
        r_busy[commit_rd] <= 1'b0;
      end
      if (w_issue_en) begin
        r_busy[issue_rd] <= 1'b1;
      end
    end
  end

  // Rename tags: only an accepted issue changes a tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        r_tags[i] <= {RW{1'b0}};
      end
    end else if (w_issue_en) begin
      r_tags[issue_rd] <= issue_rob_id;
    end
  end

  // Read the pre-edge state for both source operands.
  always_comb begin
    w_sval1  = r_values[rs1];
    w_sval2  = r_values[rs2];
    w_sbusy1 = r_busy[rs1];
    w_sbusy2 = r_busy[rs2];
    w_stag1  = r_tags[rs1];
    w_stag2  = r_tags[rs2];
  end

`ifdef REG_COMMIT_BYPASS_EN
  // Forward a commit that retires exactly the tag an operand is waiting on.
  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
    if (rdy && (commit_rd != 5'd0)) begin
      w_byp1 = (commit_rd == rs1) && w_sbusy1 && (w_stag1 == commit_rob_id);
      w_byp2 = (commit_rd == rs2) && w_sbusy2 && (w_stag2 == commit_rob_id);
    end else begin
      w_byp1 = 1'b0;
      w_byp2 = 1'b0;
    end
  end
`else
  // No commit forwarding in this build.
  always_comb begin
    w_byp1 = 1'b0;
    w_byp2 = 1'b0;
  end
`endif

  // Resolve both operands and drive the query outputs.
  always_comb begin
    w_res1 = resolve_operand(rs1, w_sbusy1, w_stag1, w_sval1, w_byp1, commit_value,
                             get_ready1, get_value1);
    w_res2 = resolve_operand(rs2, w_sbusy2, w_stag2, w_sval2, w_byp2, commit_value,
                             get_ready2, get_value2);
    val1        = w_res1[RES_W-1 -: 32];
    has_dep1    = w_res1[RW];
    dep1        = w_res1[RW-1:0];
    val2        = w_res2[RES_W-1 -: 32];
    has_dep2    = w_res2[RW];
    dep2        = w_res2[RW-1:0];
    get_rob_id1 = w_stag1;
    get_rob_id2 = w_stag2;
  end

endmodule
